// File: rtl/rtc_pkg.sv
// Shared constants and state encoding for the RTC bus scheduler.
package rtc_pkg;
   localparam int N_REQ = 3;
   localparam int IDX_W = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_GAP  = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4,
      ST_REC  = 3'd5
   } state_t;

   // Level driven on a_d for each half of the multiplexed cycle.
   localparam logic PH_ADDR = 1'b0;
   localparam logic PH_DATA = 1'b1;

   function automatic logic [7:0] byte_sel(input logic [8*N_REQ-1:0] bus,
                                           input logic [IDX_W-1:0]   idx);
      return bus[8*idx +: 8];
   endfunction
endpackage

// File: rtl/rtc_rr_arbiter.sv
// Combinational one-hot grant for the RTC bus requesters.
// RTC_SCHED_FIXED_PRIO_EN selects fixed priority (req[0] highest) instead of round-robin.
module rtc_rr_arbiter
   import rtc_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0] o_idx
);
`ifdef RTC_SCHED_FIXED_PRIO_EN
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (i_req[k]) begin
            o_gnt    = '0;
            o_gnt[k] = 1'b1;
            o_idx    = IDX_W'(k);
         end
      end
   end
`else
   // w_cand[gi] is the requester examined gi+1 places after the last owner.
   logic [IDX_W-1:0] w_cand [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
         assign w_cand[gi] = IDX_W'((int'(i_ptr) + gi + 1) % N_REQ);
      end
   endgenerate

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (i_req[w_cand[k]]) begin
            o_gnt            = '0;
            o_gnt[w_cand[k]] = 1'b1;
            o_idx            = w_cand[k];
         end
      end
   end
`endif
endmodule

// File: rtl/rtc_bus_sched.sv
// Arbitrates three requesters onto the RTC multiplexed address/data bus and sequences each cycle.
// Optional build macro RTC_SCHED_FIXED_PRIO_EN switches the arbiter to fixed priority.
module rtc_bus_sched
   import rtc_pkg::*;
#(
   parameter int T_PULSE = 4,
   parameter int T_GAP   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     rw,
   input  logic [8*N_REQ-1:0]   addr,
   input  logic [8*N_REQ-1:0]   wdata,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     ack,
   output logic [7:0]           rdata,
   output logic                 busy,
   input  logic [7:0]           ad_in,
   output logic [7:0]           ad_out,
   output logic                 ad_oe,
   output logic                 cs_n,
   output logic                 rd_n,
   output logic                 wr_n,
   output logic                 a_d
);
   generate
      if (T_PULSE < 1 || T_PULSE > 255) begin : g_bad_pulse
         $error("rtc_bus_sched: T_PULSE must be 1..255");
      end
      if (T_GAP < 1 || T_GAP > 255) begin : g_bad_gap
         $error("rtc_bus_sched: T_GAP must be 1..255");
      end
   endgenerate

   // Counter holds cycles remaining after the current one in a timed phase.
   localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
   localparam logic [7:0] GAP_LD   = 8'(T_GAP - 1);

   state_t            r_state, r_state_next;
   logic [7:0]        r_cnt, r_cnt_next;
   logic [N_REQ-1:0]  r_gnt, r_gnt_next;
   logic              r_busy, r_busy_next;
   logic [IDX_W-1:0]  r_ptr, r_ptr_next;
   logic              r_rw, r_rw_next;
   logic [7:0]        r_addr, r_addr_next;
   logic [7:0]        r_wdata, r_wdata_next;
   logic [7:0]        r_rdata, r_rdata_next;

   logic [N_REQ-1:0]  w_arb_gnt;
   logic [IDX_W-1:0]  w_arb_idx;
   logic              w_cnt_zero;

   rtc_rr_arbiter u_arb (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx)
   );

   assign w_cnt_zero = (r_cnt == 8'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_gnt   <= '0;
         r_busy  <= 1'b0;
         r_ptr   <= IDX_W'(N_REQ - 1);
         r_rw    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= r_state_next;
         r_cnt   <= r_cnt_next;
         r_gnt   <= r_gnt_next;
         r_busy  <= r_busy_next;
         r_ptr   <= r_ptr_next;
         r_rw    <= r_rw_next;
         r_addr  <= r_addr_next;
         r_wdata <= r_wdata_next;
         r_rdata <= r_rdata_next;
      end
   end

   always_comb begin
      r_state_next = r_state;
      r_cnt_next   = r_cnt;
      r_gnt_next   = r_gnt;
      r_busy_next  = r_busy;
      r_ptr_next   = r_ptr;
      r_rw_next    = r_rw;
      r_addr_next  = r_addr;
      r_wdata_next = r_wdata;
      r_rdata_next = r_rdata;
      case (r_state)
         ST_IDLE: begin
            if (|req) begin
               r_state_next = ST_ADDR;
               r_cnt_next   = PULSE_LD;
               r_gnt_next   = w_arb_gnt;
               r_busy_next  = 1'b1;
               r_ptr_next   = w_arb_idx;
               r_rw_next    = rw[w_arb_idx];
               r_addr_next  = byte_sel(addr, w_arb_idx);
               r_wdata_next = byte_sel(wdata, w_arb_idx);
            end
         end
         ST_ADDR: begin
            if (w_cnt_zero) begin
               r_state_next = ST_GAP;
               r_cnt_next   = GAP_LD;
            end else begin
               r_cnt_next = r_cnt - 8'd1;
            end
         end
         ST_GAP: begin
            if (w_cnt_zero) begin
               r_state_next = ST_DATA;
               r_cnt_next   = PULSE_LD;
            end else begin
               r_cnt_next = r_cnt - 8'd1;
            end
         end
         ST_DATA: begin
            if (w_cnt_zero) begin
               r_state_next = ST_DONE;
               // The RTC has had the full strobe width to settle by the last cycle.
               if (r_rw) begin
                  r_rdata_next = ad_in;
               end
            end else begin
               r_cnt_next = r_cnt - 8'd1;
            end
         end
         ST_DONE: begin
            r_state_next = ST_REC;
            r_cnt_next   = GAP_LD;
         end
         ST_REC: begin
            if (w_cnt_zero) begin
               r_state_next = ST_IDLE;
               r_gnt_next   = '0;
               r_busy_next  = 1'b0;
            end else begin
               r_cnt_next = r_cnt - 8'd1;
            end
         end
         default: r_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cs_n   = 1'b1;
      rd_n   = 1'b1;
      wr_n   = 1'b1;
      a_d    = PH_ADDR;
      ad_oe  = 1'b0;
      ad_out = '0;
      ack    = '0;
      case (r_state)
         ST_ADDR: begin
            cs_n   = 1'b0;
            wr_n   = 1'b0;
            ad_oe  = 1'b1;
            ad_out = r_addr;
         end
         ST_DATA: begin
            cs_n = 1'b0;
            a_d  = PH_DATA;
            if (r_rw) begin
               rd_n = 1'b0;
            end else begin
               wr_n   = 1'b0;
               ad_oe  = 1'b1;
               ad_out = r_wdata;
            end
         end
         ST_DONE: ack = r_gnt;
         default: ;
      endcase
   end

   assign gnt   = r_gnt;
   assign busy  = r_busy;
   assign rdata = r_rdata;
endmodule

// File: tb/tb_rtc_bus_sched.sv
// Scoreboard bench for rtc_bus_sched: default-timing instance plus a T_PULSE=T_GAP=1 instance.
`timescale 1ns/1ps
module tb_rtc_bus_sched;
   typedef struct {
      logic [2:0] ack;
      logic       chk_rd;
      logic [7:0] rd;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic [2:0]  req = '0, rw = '0, gnt, ack;
   logic [23:0] addr = '0, wdata = '0;
   logic [7:0]  rdata, ad_in, ad_out, rtc_val = 8'h00;
   logic        busy, ad_oe, cs_n, rd_n, wr_n, a_d;

   logic [2:0]  f_req = '0, f_rw = '0, f_gnt, f_ack;
   logic [23:0] f_addr = '0, f_wdata = '0;
   logic [7:0]  f_rdata, f_ad_in, f_ad_out, f_rtc_val = 8'h00;
   logic        f_busy, f_ad_oe, f_cs_n, f_rd_n, f_wr_n, f_a_d;

   // RTC model: drives its register only while rd_n is low.
   assign ad_in   = rd_n   ? 8'hEE : rtc_val;
   assign f_ad_in = f_rd_n ? 8'hEE : f_rtc_val;

   rtc_bus_sched dut (
      .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
      .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .ad_in(ad_in),
      .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d)
   );

   rtc_bus_sched #(.T_PULSE(1), .T_GAP(1)) dut_f (
      .clk(clk), .reset(reset), .req(f_req), .rw(f_rw), .addr(f_addr), .wdata(f_wdata),
      .gnt(f_gnt), .ack(f_ack), .rdata(f_rdata), .busy(f_busy), .ad_in(f_ad_in),
      .ad_out(f_ad_out), .ad_oe(f_ad_oe), .cs_n(f_cs_n), .rd_n(f_rd_n), .wr_n(f_wr_n), .a_d(f_a_d)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic at(input int t0, input int k);
      while (cyc < t0 + k) @(negedge clk);
   endtask

   exp_t q_m[$];
   exp_t q_f[$];
   exp_t e_m, e_f;

   always @(negedge clk) begin
      chk("strobe_overlap", {31'd0, (rd_n == 1'b0 && wr_n == 1'b0)}, 0);
      chk("oe_during_read", {31'd0, (rd_n == 1'b0 && ad_oe == 1'b1)}, 0);
      if (ack !== 3'b000) begin
         if (q_m.size() == 0) begin
            chk("unexpected_ack", {29'd0, ack}, 0);
         end else begin
            e_m = q_m.pop_front();
            chk("ack_owner", {29'd0, ack}, {29'd0, e_m.ack});
            chk("ack_cycle", cyc, e_m.cyc);
            if (e_m.chk_rd) chk("ack_rdata", {24'd0, rdata}, {24'd0, e_m.rd});
            $display("txn main ack=%b cycle=%0d rdata=0x%02h", ack, cyc, rdata);
         end
      end
   end

   always @(negedge clk) begin
      chk("f_strobe_overlap", {31'd0, (f_rd_n == 1'b0 && f_wr_n == 1'b0)}, 0);
      chk("f_oe_during_read", {31'd0, (f_rd_n == 1'b0 && f_ad_oe == 1'b1)}, 0);
      if (f_ack !== 3'b000) begin
         if (q_f.size() == 0) begin
            chk("f_unexpected_ack", {29'd0, f_ack}, 0);
         end else begin
            e_f = q_f.pop_front();
            chk("f_ack_owner", {29'd0, f_ack}, {29'd0, e_f.ack});
            chk("f_ack_cycle", cyc, e_f.cyc);
            if (e_f.chk_rd) chk("f_ack_rdata", {24'd0, f_rdata}, {24'd0, e_f.rd});
            $display("txn fast ack=%b cycle=%0d rdata=0x%02h", f_ack, cyc, f_rdata);
         end
      end
   end

   // Single transaction on the default instance; drop=1 releases req at cycle 3.
   task automatic txn(input int idx, input logic r, input logic [7:0] a,
                      input logic [7:0] wd, input logic [7:0] rv, input logic drop);
      int t0;
      req = '0;
      req[idx] = 1'b1;
      rw[idx] = r;
      addr[8*idx +: 8] = a;
      wdata[8*idx +: 8] = wd;
      rtc_val = rv;
      t0 = cyc;
      q_m.push_back('{3'(1 << idx), r, rv, t0 + 11});
      at(t0, 1);
      chk("addr_gnt", {29'd0, gnt}, 32'(1 << idx));
      chk("addr_busy", {31'd0, busy}, 1);
      chk("addr_cs_n", {31'd0, cs_n}, 0);
      chk("addr_wr_n", {31'd0, wr_n}, 0);
      chk("addr_rd_n", {31'd0, rd_n}, 1);
      chk("addr_a_d", {31'd0, a_d}, 0);
      chk("addr_oe", {31'd0, ad_oe}, 1);
      chk("addr_out", {24'd0, ad_out}, {24'd0, a});
      if (drop) begin
         at(t0, 3);
         req[idx] = 1'b0;
      end
      at(t0, 4);
      chk("addr_end_wr_n", {31'd0, wr_n}, 0);
      at(t0, 5);
      chk("gap_cs_n", {31'd0, cs_n}, 1);
      chk("gap_wr_n", {31'd0, wr_n}, 1);
      chk("gap_oe", {31'd0, ad_oe}, 0);
      at(t0, 7);
      chk("data_cs_n", {31'd0, cs_n}, 0);
      chk("data_a_d", {31'd0, a_d}, 1);
      chk("data_rd_n", {31'd0, rd_n}, {31'd0, ~r});
      chk("data_wr_n", {31'd0, wr_n}, {31'd0, r});
      chk("data_oe", {31'd0, ad_oe}, {31'd0, ~r});
      if (!r) chk("data_out", {24'd0, ad_out}, {24'd0, wd});
      at(t0, 10);
      chk("data_end_strobe", {30'd0, rd_n, wr_n}, r ? 32'h1 : 32'h2);
      at(t0, 11);
      req[idx] = 1'b0;
      at(t0, 13);
      chk("rec_busy", {31'd0, busy}, 1);
      at(t0, 14);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_gnt", {29'd0, gnt}, 0);
      if (r) chk("rdata_held", {24'd0, rdata}, {24'd0, rv});
      if (drop) begin
         at(t0, 15);
         chk("no_regrant", {29'd0, gnt}, 0);
      end
   endtask

   // Hold a request mask for n back-to-back transactions; order packs 2-bit owner indices.
   task automatic multi(input logic [2:0] mask, input int n, input logic [7:0] order);
      int t0;
      int o;
      req = mask;
      rw = 3'b000;
      addr = 24'hC2_B1_A0;
      wdata = 24'h33_22_11;
      t0 = cyc;
      for (int i = 0; i < n; i++) begin
         o = int'(order[2*i +: 2]);
         q_m.push_back('{3'(1 << o), 1'b0, 8'h00, t0 + 14*i + 11});
      end
      for (int i = 0; i < n; i++) begin
         o = int'(order[2*i +: 2]);
         at(t0, 14*i + 1);
         chk("seq_gnt", {29'd0, gnt}, 32'(1 << o));
         chk("seq_addr", {24'd0, ad_out}, {24'd0, addr[8*o +: 8]});
      end
      at(t0, 14*(n-1) + 11);
      req = '0;
      at(t0, 14*n);
      chk("seq_idle_busy", {31'd0, busy}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int t0;
      logic [7:0] ord3, ord4;
`ifdef RTC_SCHED_FIXED_PRIO_EN
      ord3 = 8'b00_00_00_00;
      ord4 = 8'b00_00_00_00;
`else
      ord3 = 8'b00_10_01_00;
      ord4 = 8'b00_00_01_00;
`endif
      repeat (3) @(negedge clk);
      chk("rst_gnt", {29'd0, gnt}, 0);
      chk("rst_ack", {29'd0, ack}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_rdata", {24'd0, rdata}, 0);
      chk("rst_strobes", {29'd0, cs_n, rd_n, wr_n}, 32'h7);
      chk("rst_bus", {22'd0, ad_oe, a_d, ad_out}, 0);
      reset = 1'b0;

      txn(0, 1'b0, 8'h21, 8'h15, 8'h00, 1'b0);
      txn(1, 1'b1, 8'h0B, 8'h00, 8'h59, 1'b0);

      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      multi(3'b111, 4, ord3);

      // Reset in the middle of a write data phase.
      req = 3'b010;
      rw[1] = 1'b0;
      addr[15:8] = 8'h44;
      wdata[15:8] = 8'h55;
      t0 = cyc;
      at(t0, 1);
      chk("rst_mid_gnt", {29'd0, gnt}, 32'h2);
      at(t0, 8);
      reset = 1'b1;
      at(t0, 9);
      chk("rst_mid_strobes", {29'd0, cs_n, rd_n, wr_n}, 32'h7);
      chk("rst_mid_oe", {31'd0, ad_oe}, 0);
      chk("rst_mid_gnt0", {29'd0, gnt}, 0);
      chk("rst_mid_busy", {31'd0, busy}, 0);
      chk("rst_mid_rdata", {24'd0, rdata}, 0);
      reset = 1'b0;
      req = '0;
      multi(3'b011, 2, ord4);

      txn(2, 1'b0, 8'h6C, 8'h7D, 8'h00, 1'b1);

      // Minimum timing: one cycle per phase.
      f_req = 3'b001;
      f_rw = 3'b001;
      f_addr[7:0] = 8'h5A;
      f_rtc_val = 8'hA7;
      t0 = cyc;
      q_f.push_back('{3'b001, 1'b1, 8'hA7, t0 + 4});
      at(t0, 1);
      chk("f_addr_strobe", {30'd0, f_cs_n, f_wr_n}, 0);
      chk("f_addr_out", {24'd0, f_ad_out}, 32'h5A);
      at(t0, 2);
      chk("f_gap_cs_n", {31'd0, f_cs_n}, 1);
      chk("f_gap_oe", {31'd0, f_ad_oe}, 0);
      at(t0, 3);
      chk("f_data_rd_n", {31'd0, f_rd_n}, 0);
      chk("f_data_a_d", {31'd0, f_a_d}, 1);
      at(t0, 4);
      f_req = '0;
      at(t0, 5);
      chk("f_rec_busy", {31'd0, f_busy}, 1);
      at(t0, 6);
      chk("f_idle_busy", {31'd0, f_busy}, 0);

      repeat (20) @(negedge clk);
      chk("main_queue_empty", q_m.size(), 0);
      chk("fast_queue_empty", q_f.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
